// File: rtl/tron_pkg.sv
// Shared definitions for the instruction controller: opcode/ext encodings,
// FSM state type, datapath select codes and the decoder output record.
package tron_pkg;

  localparam int WIDTH   = 16;
  localparam int REGBITS = 4;

  // Primary opcodes, IR[15:12]. Immediate-format opcodes reuse the
  // register-format ext code of the same operation.
  localparam logic [3:0] OP_REG   = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_JMPI  = 4'b1110;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  // Extension codes, IR[7:4].
  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_OR   = 4'b0010;
  localparam logic [3:0] EXT_XOR  = 4'b0011;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_MOV  = 4'b1101;
  localparam logic [3:0] EXT_LOAD = 4'b0000;
  localparam logic [3:0] EXT_STOR = 4'b0100;
  localparam logic [3:0] EXT_LSH  = 4'b0100;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_PCUPD  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_CMP = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  localparam logic [3:0] ALU_MOV = 4'd6;

  localparam logic [2:0] BUS_IMM   = 3'd0;
  localparam logic [2:0] BUS_MEM   = 3'd1;
  localparam logic [2:0] BUS_ALU   = 3'd2;
  localparam logic [2:0] BUS_SHIFT = 3'd3;
  localparam logic [2:0] BUS_PC    = 3'd4;
  localparam logic [2:0] BUS_REGB  = 3'd5;

  localparam logic [1:0] SH_LSH  = 2'd0;  // shift amount from register
  localparam logic [1:0] SH_LSHI = 2'd1;  // shift amount from immediate

  typedef struct packed {
    logic [3:0]       alu_op;
    logic [1:0]       shift_op;
    logic [2:0]       bus_op;
    logic             imm_mux;
    logic [WIDTH-1:0] immediate;
    logic             reg_wr_exec;  // register write in EXEC
    logic             reg_wr_mem;   // register write in MEM (LOAD)
    logic             mem_wr;       // memory write in MEM (STOR)
    logic             is_mem;       // instruction visits MEM
    logic             branch;
    logic             jump;
    logic             illegal;
  } decode_t;

  // Maps an ALU ext code to {valid, ALUOp}.
  function automatic logic [4:0] alu_from_ext(input logic [3:0] ext);
    logic [4:0] r;
    r = 5'b0;
    case (ext)
      EXT_ADD: r = {1'b1, ALU_ADD};
      EXT_SUB: r = {1'b1, ALU_SUB};
      EXT_CMP: r = {1'b1, ALU_CMP};
      EXT_AND: r = {1'b1, ALU_AND};
      EXT_OR:  r = {1'b1, ALU_OR};
      EXT_XOR: r = {1'b1, ALU_XOR};
      EXT_MOV: r = {1'b1, ALU_MOV};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Purely combinational instruction decode: IR in, control fields plus an
// illegal-encoding flag out. Sequencing is left to the controller FSM.
module instruction_decoder
  import tron_pkg::*;
(
  input  logic [WIDTH-1:0] ir_i,
  output decode_t          dec_o
);

  logic [3:0] op;
  logic [3:0] ext;
  logic [4:0] alu_reg;
  logic [4:0] alu_imm;

  assign op      = ir_i[15:12];
  assign ext     = ir_i[7:4];
  assign alu_reg = alu_from_ext(ext);
  assign alu_imm = alu_from_ext(op);

  // Field decode by instruction class; unknown encodings raise illegal.
  always_comb begin
    dec_o         = '0;
    dec_o.bus_op  = BUS_ALU;
    case (op)
      OP_REG: begin
        if (alu_reg[4]) begin
          dec_o.alu_op      = alu_reg[3:0];
          dec_o.reg_wr_exec = (ext != EXT_CMP);
        end else begin
          dec_o.illegal = 1'b1;
        end
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_SUBI, OP_CMPI, OP_MOVI: begin
        dec_o.alu_op      = alu_imm[3:0];
        dec_o.imm_mux     = 1'b1;
        dec_o.reg_wr_exec = (op != OP_CMPI);
        // Logical ops zero-extend; arithmetic and MOVI sign-extend.
        if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
          dec_o.immediate = {8'h00, ir_i[7:0]};
        else
          dec_o.immediate = {{8{ir_i[7]}}, ir_i[7:0]};
      end
      OP_LUI: begin
        dec_o.immediate   = {ir_i[7:0], 8'h00};
        dec_o.imm_mux     = 1'b1;
        dec_o.bus_op      = BUS_IMM;
        dec_o.reg_wr_exec = 1'b1;
      end
      OP_SHIFT: begin
        dec_o.bus_op = BUS_SHIFT;
        if (ext == EXT_LSH) begin
          dec_o.shift_op    = SH_LSH;
          dec_o.reg_wr_exec = 1'b1;
        end else if (ext[3:1] == 3'b000) begin
          dec_o.shift_op    = SH_LSHI;
          dec_o.imm_mux     = 1'b1;
          dec_o.immediate   = {{11{ir_i[4]}}, ir_i[4:0]};
          dec_o.reg_wr_exec = 1'b1;
        end else begin
          dec_o.illegal = 1'b1;
        end
      end
      OP_MEM: begin
        if (ext == EXT_LOAD) begin
          dec_o.bus_op     = BUS_MEM;
          dec_o.is_mem     = 1'b1;
          dec_o.reg_wr_mem = 1'b1;
        end else if (ext == EXT_STOR) begin
          dec_o.bus_op = BUS_REGB;
          dec_o.is_mem = 1'b1;
          dec_o.mem_wr = 1'b1;
        end else begin
          dec_o.illegal = 1'b1;
        end
      end
      OP_BCOND: begin
        dec_o.immediate = {{8{ir_i[7]}}, ir_i[7:0]};
        dec_o.bus_op    = BUS_PC;
        dec_o.branch    = 1'b1;
      end
      OP_JMPI: begin
        dec_o.immediate = {4'h0, ir_i[11:0]};
        dec_o.bus_op    = BUS_PC;
        dec_o.jump      = 1'b1;
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instruction_controller.sv
// Multi-cycle instruction controller: fetch, latch, decode and sequence the
// datapath strobes one instruction at a time. Decode outputs come only from
// the latched IR, so nothing on instr_in reaches an output combinationally.
// Handshake: instr_in is accepted on any rising edge where the FSM is in
// FETCH (fetch_req=1) and instr_valid=1; instr_valid is ignored otherwise.
module instruction_controller
  import tron_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        instr_in,
  input  logic               instr_valid,
  output logic               fetch_req,
  output logic [7:0]         instructionOp,
  output logic [WIDTH-1:0]   immediate,
  output logic [REGBITS-1:0] regAddA,
  output logic [REGBITS-1:0] regAddB,
  output logic [3:0]         ALUOp,
  output logic [1:0]         shiftOp,
  output logic [2:0]         busOp,
  output logic               immMUX,
  output logic               regWrite,
  output logic               memWrite,
  output logic [3:0]         flagOp,
  output logic               pcAdd,
  output logic               pcJump,
  output logic               pcBranch,
  output logic               halted,
  output state_t             state_dbg
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        halted_q, halted_d;
  decode_t     dec;

  instruction_decoder u_dec (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  // State, IR and halt flag; reset returns to an idle FETCH immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      ir_q     <= 16'h0000;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  // Next-state logic; IR only loads in FETCH on a valid word.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    halted_d = halted_q;
    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec.illegal) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = dec.is_mem ? S_MEM : S_PCUPD;
      S_MEM:   state_d = S_PCUPD;
      S_PCUPD: state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes: each is a single-state decode, so it is one cycle wide and
  // falls as soon as reset forces the state back to FETCH.
  always_comb begin
    fetch_req = (state_q == S_FETCH) && !reset;
    regWrite  = ((state_q == S_EXEC) && dec.reg_wr_exec) ||
                ((state_q == S_MEM)  && dec.reg_wr_mem);
    memWrite  = (state_q == S_MEM)   && dec.mem_wr;
    pcAdd     = (state_q == S_PCUPD) && !dec.branch && !dec.jump;
    pcBranch  = (state_q == S_PCUPD) && dec.branch;
    pcJump    = (state_q == S_PCUPD) && dec.jump;
  end

  // Decode fields follow the latched IR and so hold steady DECODE..PCUPD.
  always_comb begin
    instructionOp = {ir_q[15:12], ir_q[7:4]};
    regAddA       = ir_q[3:0];
    regAddB       = ir_q[11:8];
    flagOp        = ir_q[11:8];
    immediate     = dec.immediate;
    ALUOp         = dec.alu_op;
    shiftOp       = dec.shift_op;
    busOp         = dec.bus_op;
    immMUX        = dec.imm_mux;
    halted        = halted_q;
    state_dbg     = state_q;
  end

endmodule

// File: tb/tb_instruction_controller.sv
// Directed bench for instruction_controller: a table of instructions with
// hand-computed decode fields and per-cycle strobe patterns, followed by
// hand-written reset, halt and mid-instruction reset sequences.
module tb_instruction_controller;
  import tron_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        fetch_req;
  logic [7:0]  instructionOp;
  logic [15:0] immediate;
  logic [3:0]  regAddA, regAddB, ALUOp, flagOp;
  logic [1:0]  shiftOp;
  logic [2:0]  busOp;
  logic        immMUX, regWrite, memWrite, pcAdd, pcJump, pcBranch, halted;
  state_t      state_dbg;

  instruction_controller #(.WIDTH(16), .REGBITS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_in      (instr_in),
    .instr_valid   (instr_valid),
    .fetch_req     (fetch_req),
    .instructionOp (instructionOp),
    .immediate     (immediate),
    .regAddA       (regAddA),
    .regAddB       (regAddB),
    .ALUOp         (ALUOp),
    .shiftOp       (shiftOp),
    .busOp         (busOp),
    .immMUX        (immMUX),
    .regWrite      (regWrite),
    .memWrite      (memWrite),
    .flagOp        (flagOp),
    .pcAdd         (pcAdd),
    .pcJump        (pcJump),
    .pcBranch      (pcBranch),
    .halted        (halted),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Strobe vectors: bit k set = strobe high k cycles after the FETCH cycle
  // in which the instruction was presented (1=DECODE, 2=EXEC, ...).
  // dc bits: 0 immediate, 1 ALUOp, 2 busOp, 3 immMUX are not checked.
  typedef struct {
    logic [15:0] instr;
    int          len;
    logic [15:0] rw;
    logic [15:0] mw;
    logic [15:0] pa;
    logic [15:0] pb;
    logic [15:0] pj;
    logic [15:0] imm;
    logic [3:0]  alu;
    logic [2:0]  bus;
    logic        mux;
    logic [3:0]  dc;
  } vec_t;

  localparam logic [15:0] B2 = 16'h0004;
  localparam logic [15:0] B3 = 16'h0008;
  localparam logic [15:0] B4 = 16'h0010;
  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  // ---------------- driver ----------------
  // Starts in a FETCH cycle, presents one instruction and watches it to
  // the next FETCH. While busy it drives an illegal word with valid high,
  // which must not disturb the IR.
  task automatic run_vec(input vec_t v, input int idx);
    logic [15:0] rw, mw, pa, pb, pj;
    int len;
    string tag;
    tag = $sformatf("v%0d_%h", idx, v.instr);
    rw = '0; mw = '0; pa = '0; pb = '0; pj = '0; len = 0;
    chk({tag, "_fetch_idle"}, {31'b0, fetch_req}, 32'd1);
    instr_in    = v.instr;
    instr_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (fetch_req) begin
        len = k;
        instr_valid = 1'b0;
        break;
      end
      rw[k] = regWrite; mw[k] = memWrite;
      pa[k] = pcAdd;    pb[k] = pcBranch; pj[k] = pcJump;
      if (k == 1) begin
        chk({tag, "_regA"},  {28'b0, regAddA}, {28'b0, v.instr[3:0]});
        chk({tag, "_regB"},  {28'b0, regAddB}, {28'b0, v.instr[11:8]});
        chk({tag, "_flag"},  {28'b0, flagOp},  {28'b0, v.instr[11:8]});
        chk({tag, "_iop"},   {24'b0, instructionOp}, {24'b0, v.instr[15:12], v.instr[7:4]});
        if (!v.dc[0]) chk({tag, "_imm"}, {16'b0, immediate}, {16'b0, v.imm});
        if (!v.dc[1]) chk({tag, "_alu"}, {28'b0, ALUOp}, {28'b0, v.alu});
        if (!v.dc[2]) chk({tag, "_bus"}, {29'b0, busOp}, {29'b0, v.bus});
        if (!v.dc[3]) chk({tag, "_mux"}, {31'b0, immMUX}, {31'b0, v.mux});
        instr_in = 16'h7000;
      end
    end
    instr_valid = 1'b0;
    chk({tag, "_len"},      len,           v.len);
    chk({tag, "_regWrite"}, {16'b0, rw},   {16'b0, v.rw});
    chk({tag, "_memWrite"}, {16'b0, mw},   {16'b0, v.mw});
    chk({tag, "_pcAdd"},    {16'b0, pa},   {16'b0, v.pa});
    chk({tag, "_pcBranch"}, {16'b0, pb},   {16'b0, v.pb});
    chk({tag, "_pcJump"},   {16'b0, pj},   {16'b0, v.pj});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    logic any;
    //            instr     len rw  mw  pa  pb  pj  imm       alu bus mux dc
    vecs[0]  = '{16'h0351, 4, B2, 0,  B3, 0,  0,  16'h0000, 0,  2,  0,  4'b0001}; // ADD
    vecs[1]  = '{16'h0291, 4, B2, 0,  B3, 0,  0,  16'h0000, 1,  2,  0,  4'b0001}; // SUB
    vecs[2]  = '{16'h04B5, 4, 0,  0,  B3, 0,  0,  16'h0000, 2,  0,  0,  4'b0101}; // CMP
    vecs[3]  = '{16'h0731, 4, B2, 0,  B3, 0,  0,  16'h0000, 5,  2,  0,  4'b0001}; // XOR
    vecs[4]  = '{16'h08D2, 4, B2, 0,  B3, 0,  0,  16'h0000, 6,  2,  0,  4'b0001}; // MOV
    vecs[5]  = '{16'h52FF, 4, B2, 0,  B3, 0,  0,  16'hFFFF, 0,  2,  1,  4'b0000}; // ADDI
    vecs[6]  = '{16'h12FF, 4, B2, 0,  B3, 0,  0,  16'h00FF, 3,  2,  1,  4'b0000}; // ANDI
    vecs[7]  = '{16'hF2AB, 4, B2, 0,  B3, 0,  0,  16'hAB00, 0,  0,  1,  4'b0110}; // LUI
    vecs[8]  = '{16'hB380, 4, 0,  0,  B3, 0,  0,  16'hFF80, 2,  0,  1,  4'b0100}; // CMPI
    vecs[9]  = '{16'hD47F, 4, B2, 0,  B3, 0,  0,  16'h007F, 6,  2,  1,  4'b0000}; // MOVI
    vecs[10] = '{16'h8314, 4, B2, 0,  B3, 0,  0,  16'hFFF4, 0,  3,  1,  4'b0010}; // LSHI
    vecs[11] = '{16'h8245, 4, B2, 0,  B3, 0,  0,  16'h0000, 0,  3,  0,  4'b0011}; // LSH
    vecs[12] = '{16'h4142, 5, 0,  B3, B4, 0,  0,  16'h0000, 0,  0,  0,  4'b1111}; // STOR
    vecs[13] = '{16'h4102, 5, B3, 0,  B4, 0,  0,  16'h0000, 0,  1,  0,  4'b1011}; // LOAD
    vecs[14] = '{16'hC0FE, 4, 0,  0,  0,  B3, 0,  16'hFFFE, 0,  0,  0,  4'b1110}; // Bcond
    vecs[15] = '{16'hE123, 4, 0,  0,  0,  0,  B3, 16'h0123, 0,  0,  0,  4'b1110}; // JMPI

    // Reset state
    reset = 1'b1; instr_in = 16'h0000; instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fetch_req", {31'b0, fetch_req}, 32'd0);
    chk("rst_state",     {29'b0, state_dbg}, {29'b0, S_FETCH});
    chk("rst_halted",    {31'b0, halted},    32'd0);
    chk("rst_iop",       {24'b0, instructionOp}, 32'd0);
    chk("rst_strobes",   {26'b0, regWrite, memWrite, pcAdd, pcBranch, pcJump, 1'b0}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_fetch_req", {31'b0, fetch_req}, 32'd1);

    // Table-driven instructions
    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Illegal opcode halts until reset
    instr_in = 16'h7000; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("ill_decode_state", {29'b0, state_dbg}, {29'b0, S_DECODE});
    chk("ill_decode_halted", {31'b0, halted}, 32'd0);
    @(posedge clk); #1;
    chk("ill_halted", {31'b0, halted}, 32'd1);
    chk("ill_state",  {29'b0, state_dbg}, {29'b0, S_HALT});
    any = 1'b0;
    instr_in = 16'h0351; instr_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      any = any | fetch_req | regWrite | memWrite | pcAdd | pcBranch | pcJump;
    end
    instr_valid = 1'b0;
    chk("ill_quiet_10", {31'b0, any}, 32'd0);
    chk("ill_sticky",   {31'b0, halted}, 32'd1);
    @(negedge clk);
    reset = 1'b1; #1;
    chk("ill_rst_halted", {31'b0, halted}, 32'd0);
    chk("ill_rst_fetch",  {31'b0, fetch_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0; #1;
    chk("ill_rel_fetch", {31'b0, fetch_req}, 32'd1);

    // Reset asserted during EXEC of an ADD: no write completes
    instr_in = 16'h0351; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("rx_in_exec", {29'b0, state_dbg}, {29'b0, S_EXEC});
    reset = 1'b1; #1;
    chk("rx_rw_drop", {31'b0, regWrite}, 32'd0);
    chk("rx_state",   {29'b0, state_dbg}, {29'b0, S_FETCH});
    any = 1'b0;
    @(posedge clk); #1;
    any = any | regWrite | pcAdd;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      any = any | regWrite | pcAdd;
    end
    chk("rx_no_strobe", {31'b0, any}, 32'd0);
    chk("rx_idle_state", {29'b0, state_dbg}, {29'b0, S_FETCH});

    // Recovery: a normal instruction after the aborted one
    run_vec(vecs[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
